// File: rtl/mdu_seq32_pkg.sv
// Shared definitions for the iterative multiply/divide unit: widths,
// operation and state encodings, and the divide-by-zero quotient.
package mdu_pkg;

    localparam int MDU_WIDTH  = 32;
    localparam int MDU_ADDR_W = 5;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic [MDU_WIDTH-1:0] DIV0_QUOT = 32'hFFFFFFFF;

    // Divide-family ops share the restoring-division datapath.
    function automatic logic is_div(input op_e op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/mdu_seq32_if.sv
// Control-unit / register-file handshake bundle for the multiply/divide unit.
// The control side drives the request, the unit drives the write port.
interface mdu_seq32_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic              Start;
    logic [1:0]        Op;
    logic [ADDR_W-1:0] Dest_Addr;
    logic [WIDTH-1:0]  Op_A;
    logic [WIDTH-1:0]  Op_B;
    logic              Busy;
    logic              Done;
    logic              Reg_Write;
    logic [ADDR_W-1:0] W_Addr;
    logic [WIDTH-1:0]  W_Data;

    modport master (
        output Start, Op, Dest_Addr, Op_A, Op_B,
        input  Busy, Done, Reg_Write, W_Addr, W_Data
    );

    modport slave (
        input  Start, Op, Dest_Addr, Op_A, Op_B,
        output Busy, Done, Reg_Write, W_Addr, W_Data
    );
endinterface

// File: rtl/mdu_seq32_step.sv
// One iteration of the multiply/divide datapath (purely combinational).
// Multiply: shift-add, LSB of the multiplier first, 2*WIDTH accumulator.
// Divide: restoring division, MSB of the dividend first, WIDTH+1 remainder
// kept in the low bits of the accumulator; i_q carries dividend/quotient.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_q,
    input  logic [WIDTH-1:0]   i_opnd,
    input  logic               i_div,
    output logic [2*WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0]   o_q
);
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    // Compute both candidate updates and select by mode.
    always_comb begin
        w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_q[0] ? {1'b0, i_opnd} : '0);
        w_shift = {i_acc[WIDTH-1:0], i_q[WIDTH-1]};
        w_diff  = w_shift - {1'b0, i_opnd};
        if (i_div) begin
            // Negative trial difference means restore; a zero divisor never
            // goes negative, yielding all-ones quotient and remainder = dividend.
            if (w_diff[WIDTH]) begin
                o_acc = {{(WIDTH-1){1'b0}}, w_shift};
                o_q   = {i_q[WIDTH-2:0], 1'b0};
            end else begin
                o_acc = {{(WIDTH-1){1'b0}}, w_diff};
                o_q   = {i_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            o_acc = {w_sum, i_acc[WIDTH-1:1]};
            o_q   = {1'b0, i_q[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/mdu_seq32.sv
// Iterative 32-bit unsigned multiply/divide unit with start/busy/done
// handshake, writing its result through the register-file write port.
// Optional macro MDU_EARLY_ZERO_EN: zero operands finish at the accept edge.
import mdu_pkg::*;

module mdu_seq32 #(
    parameter int WIDTH  = MDU_WIDTH,
    parameter int ADDR_W = MDU_ADDR_W
) (
    input  logic        clk_MDU,
    input  logic        rst_n,
    mdu_seq32_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    state_e              r_state;
    state_e              w_state_nxt;
    op_e                 r_op;
    logic [ADDR_W-1:0]   r_dest;
    logic [WIDTH-1:0]    r_opnd;
    logic [WIDTH-1:0]    r_q;
    logic [2*WIDTH-1:0]  r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [WIDTH-1:0]    r_wdata;
    logic [ADDR_W-1:0]   r_waddr;

    logic [2*WIDTH-1:0]  w_acc_nxt;
    logic [WIDTH-1:0]    w_q_nxt;
    logic [WIDTH-1:0]    w_result;
    logic                w_last;
    logic                w_busy;
    logic                w_done;
    logic                w_wr;
    op_e                 w_in_op;

    assign w_in_op = op_e'(bus.Op);
    assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .i_acc  (r_acc),
        .i_q    (r_q),
        .i_opnd (r_opnd),
        .i_div  (is_div(r_op)),
        .o_acc  (w_acc_nxt),
        .o_q    (w_q_nxt)
    );

    // Pick the final result from the last iteration's outputs.
    always_comb begin
        w_result = w_acc_nxt[WIDTH-1:0];
        case (r_op)
            OP_MULHU: w_result = w_acc_nxt[2*WIDTH-1:WIDTH];
            OP_DIVU:  w_result = w_q_nxt;
            default:  w_result = w_acc_nxt[WIDTH-1:0];
        endcase
    end

`ifdef MDU_EARLY_ZERO_EN
    logic             w_early;
    logic [WIDTH-1:0] w_early_res;

    // Detect operands whose result is known without iterating.
    always_comb begin
        w_early     = is_div(w_in_op) ? (bus.Op_B == '0)
                                      : ((bus.Op_A == '0) || (bus.Op_B == '0));
        w_early_res = '0;
        case (w_in_op)
            OP_DIVU: w_early_res = DIV0_QUOT;
            OP_REMU: w_early_res = bus.Op_A;
            default: w_early_res = '0;
        endcase
    end
`endif

    // State register.
    always_ff @(posedge clk_MDU or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; Start is only looked at while idle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.Start) begin
`ifdef MDU_EARLY_ZERO_EN
                    w_state_nxt = w_early ? ST_DONE : ST_RUN;
`else
                    w_state_nxt = ST_RUN;
`endif
                end
            end
            ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        w_busy = (r_state != ST_IDLE);
        w_done = (r_state == ST_DONE);
        w_wr   = w_done && (r_waddr != '0);
    end

    assign bus.Busy      = w_busy;
    assign bus.Done      = w_done;
    assign bus.Reg_Write = w_wr;
    assign bus.W_Addr    = r_waddr;
    assign bus.W_Data    = r_wdata;

    // Operand latch, iteration, and result capture; outputs hold between ops.
    always_ff @(posedge clk_MDU or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= OP_MUL;
            r_dest  <= '0;
            r_opnd  <= '0;
            r_q     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_wdata <= '0;
            r_waddr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.Start) begin
                        r_op   <= w_in_op;
                        r_dest <= bus.Dest_Addr;
                        r_opnd <= is_div(w_in_op) ? bus.Op_B : bus.Op_A;
                        r_q    <= is_div(w_in_op) ? bus.Op_A : bus.Op_B;
                        r_acc  <= '0;
                        r_cnt  <= '0;
`ifdef MDU_EARLY_ZERO_EN
                        if (w_early) begin
                            r_wdata <= w_early_res;
                            r_waddr <= bus.Dest_Addr;
                        end
`endif
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_wdata <= w_result;
                        r_waddr <= r_dest;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
